// File: rtl/axi4_wr_burst_slave.sv
// AXI4 write-burst slave: one AW burst at a time, one memory write per W beat,
// FIXED/INCR/WRAP address generation and SLVERR reporting on the B channel.
module axi4_wr_burst_slave #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ID_W-1:0]   AWID,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [7:0]        AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [STRB_W-1:0] WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb
);

  localparam logic [2:0] SZ_MAX = 3'($clog2(STRB_W));

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic              err_q, err_d;
  logic              perr_q, perr_d;
  logic              awready_q, awready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [ID_W-1:0]   bid_q, bid_d;

  logic              pre_err;
  logic              beat;
  logic              last;
  logic              lerr;
  logic [ADDR_W-1:0] nbytes;
  logic [ADDR_W-1:0] bound;
  logic [ADDR_W-1:0] next_addr;

  assign AWREADY   = awready_q;
  assign BVALID    = bvalid_q;
  assign BID       = bid_q;
  assign BRESP     = bresp_q;
  // Error bursts drain W without touching memory
  assign WREADY    = (state_q == DATA) & (err_q | mem_ready);
  assign mem_valid = (state_q == DATA) & ~err_q & WVALID;
  assign mem_addr  = addr_q;
  assign mem_wdata = WDATA;
  assign mem_wstrb = WSTRB;

  assign beat = WVALID & WREADY;
  assign last = (cnt_q == len_q);
  assign lerr = WLAST ^ last;

  always_comb begin
    pre_err = 1'b0;
    if (AWSIZE > SZ_MAX) pre_err = 1'b1;
    if (AWBURST == 2'b11) pre_err = 1'b1;
    if (AWBURST == 2'b10) begin
      if (!(AWLEN inside {8'd1, 8'd3, 8'd7, 8'd15}))
        pre_err = 1'b1;
      if ((AWADDR & ((ADDR_W'(1) << AWSIZE) - ADDR_W'(1))) != '0)
        pre_err = 1'b1;
    end
  end

  always_comb begin
    nbytes = ADDR_W'(1) << size_q;
    bound  = (ADDR_W'(len_q) + ADDR_W'(1)) << size_q;
    case (burst_q)
      2'b01:   next_addr = (addr_q & ~(nbytes - ADDR_W'(1))) + nbytes;
      2'b10:   next_addr = (addr_q & ~(bound - ADDR_W'(1)))
                         | ((addr_q + nbytes) & (bound - ADDR_W'(1)));
      default: next_addr = addr_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    size_d   = size_q;
    burst_d  = burst_q;
    err_d    = err_q;
    perr_d   = perr_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    bid_d    = bid_q;
    case (state_q)
      IDLE: begin
        if (AWVALID && awready_q) begin
          id_d    = AWID;
          addr_d  = AWADDR;
          len_d   = AWLEN;
          size_d  = AWSIZE;
          burst_d = AWBURST;
          cnt_d   = 8'd0;
          err_d   = pre_err;
          perr_d  = 1'b0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (beat) begin
          addr_d = next_addr;
          cnt_d  = cnt_q + 8'd1;
          perr_d = perr_q | lerr;
          if (last) begin
            state_d  = RESP;
            bvalid_d = 1'b1;
            bid_d    = id_q;
            bresp_d  = (err_q | perr_q | lerr) ? 2'b10 : 2'b00;
          end
        end
      end
      RESP: begin
        if (BREADY) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    awready_d = (state_d == IDLE);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      err_q     <= 1'b0;
      perr_q    <= 1'b0;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      bid_q     <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      err_q     <= err_d;
      perr_q    <= perr_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
    end
  end

endmodule

// File: tb/tb_axi4_wr_burst_slave.sv
// Bench for axi4_wr_burst_slave: directed burst table, random bursts against
// an arithmetic address/response model, and reset / B-backpressure sequences.
module tb_axi4_wr_burst_slave;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  int errors = 0;
  int checks = 0;

  always #5 ACLK = ~ACLK;

  axi4_wr_burst_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
    .WREADY(WREADY), .BID(BID), .BRESP(BRESP), .BVALID(BVALID),
    .BREADY(BREADY), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  typedef struct {
    int          id;
    int          burst;
    logic [31:0] addr;
    int          len;
    int          sz;
    int          bad;
    int          rmode;
    int          bhold;
    logic [1:0]  resp;
  } vec_t;

  vec_t vec[12];

  task automatic chk(input bit ok, input string nm,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic bit model_err(int b, logic [31:0] a, int len, int sz);
    logic [31:0] nb;
    if (sz > 2) return 1'b1;
    if (b == 3) return 1'b1;
    nb = 32'd1 << sz;
    if (b == 2 && !(len == 1 || len == 3 || len == 7 || len == 15))
      return 1'b1;
    if (b == 2 && (a % nb) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_addr(int b, logic [31:0] a,
                                            int len, int sz, int i);
    logic [31:0] nb, bnd, base;
    nb = 32'd1 << sz;
    if (b == 0) return a;
    if (b == 1) return (i == 0) ? a : (a / nb) * nb + nb * 32'(i);
    bnd  = nb * 32'(len + 1);
    base = (a / bnd) * bnd;
    return base + ((a - base + nb * 32'(i)) % bnd);
  endfunction

  task automatic run_burst(input int id, input int b, input logic [31:0] a,
                           input int len, input int sz, input int bad,
                           input int rmode, input int bhold,
                           input logic [1:0] resp);
    logic [31:0] sent[$];
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    bit perr;
    int i, t, n, nexp;
    perr = model_err(b, a, len, sz);
    AWID = 4'(id); AWADDR = a; AWLEN = 8'(len);
    AWSIZE = 3'(sz); AWBURST = 2'(b); AWVALID = 1'b1;
    t = 0;
    #1;
    while (!AWREADY && t < 20) begin
      @(negedge ACLK); #1; t++;
    end
    chk(AWREADY, "aw_handshake", 64'(AWREADY), 64'd1);
    @(negedge ACLK);
    AWVALID = 1'b0;
    i = 0; t = 0; n = 0;
    while (i <= len && t < 400) begin
      WVALID = (rmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      WDATA = $urandom;
      WSTRB = 4'($urandom);
      WLAST = ((i == len) != (i == bad));
      if (rmode == 0) mem_ready = 1'b1;
      else if (rmode == 1) mem_ready = (n % 2 == 0);
      else mem_ready = ($urandom_range(0, 2) != 0);
      #1;
      chk(!AWREADY, "aw_blocked", 64'(AWREADY), 64'd0);
      chk(WREADY == (perr ? 1'b1 : mem_ready), "wready",
          64'(WREADY), 64'(perr ? 1'b1 : mem_ready));
      chk(mem_valid == (!perr && WVALID), "mem_valid",
          64'(mem_valid), 64'(!perr && WVALID));
      if (mem_valid && mem_ready) begin
        wa.push_back(mem_addr);
        wd.push_back(mem_wdata);
        chk(mem_wstrb == WSTRB, "mem_wstrb", 64'(mem_wstrb), 64'(WSTRB));
      end
      if (WVALID && WREADY) begin
        sent.push_back(WDATA);
        i++;
      end
      n++; t++;
      @(negedge ACLK);
    end
    WVALID = 1'b0; WLAST = 1'b0; mem_ready = 1'b0;
    chk(t < 400, "w_timeout", 64'(t), 64'd400);
    #1;
    chk(BVALID, "b_latency", 64'(BVALID), 64'd1);
    nexp = perr ? 0 : len + 1;
    chk(wa.size() == nexp, "write_count", 64'(wa.size()), 64'(nexp));
    for (int k = 0; k < wa.size() && k < nexp; k++) begin
      chk(wa[k] == exp_addr(b, a, len, sz, k), "mem_addr",
          64'(wa[k]), 64'(exp_addr(b, a, len, sz, k)));
      chk(wd[k] == sent[k], "mem_wdata", 64'(wd[k]), 64'(sent[k]));
    end
    for (int h = 0; h < bhold; h++) begin
      chk(BVALID && BID == 4'(id) && BRESP == resp, "b_hold",
          {BVALID, BID, BRESP}, {1'b1, 4'(id), resp});
      chk(!AWREADY, "aw_in_resp", 64'(AWREADY), 64'd0);
      @(negedge ACLK); #1;
    end
    chk(BVALID, "bvalid", 64'(BVALID), 64'd1);
    chk(BID == 4'(id), "bid", 64'(BID), 64'(id));
    chk(BRESP == resp, "bresp", 64'(BRESP), 64'(resp));
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    #1;
    chk(!BVALID, "b_release", 64'(BVALID), 64'd0);
  endtask

  initial begin
    vec[0]  = '{5, 1, 32'h100, 3, 2, -1, 0, 0, 2'b00};
    vec[1]  = '{3, 2, 32'h38, 3, 2, -1, 0, 0, 2'b00};
    vec[2]  = '{9, 0, 32'h200, 2, 2, -1, 1, 0, 2'b00};
    vec[3]  = '{1, 1, 32'h40, 1, 3, -1, 0, 0, 2'b10};
    vec[4]  = '{2, 3, 32'h40, 1, 2, -1, 0, 0, 2'b10};
    vec[5]  = '{6, 1, 32'h10, 2, 2, 1, 0, 0, 2'b10};
    vec[6]  = '{7, 1, 32'h20, 0, 2, 0, 0, 0, 2'b10};
    vec[7]  = '{10, 1, 32'h300, 1, 2, -1, 0, 5, 2'b00};
    vec[8]  = '{11, 2, 32'h40, 2, 2, -1, 0, 0, 2'b10};
    vec[9]  = '{12, 2, 32'h3A, 3, 2, -1, 0, 0, 2'b10};
    vec[10] = '{13, 1, 32'h103, 2, 2, -1, 0, 1, 2'b00};
    vec[11] = '{14, 1, 32'hFFFF_FFF8, 3, 2, -1, 2, 2, 2'b00};

    ARESET = 1'b1; AWVALID = 1'b0; WVALID = 1'b0; WLAST = 1'b0;
    BREADY = 1'b0; mem_ready = 1'b0; AWID = '0; AWADDR = '0;
    AWLEN = '0; AWSIZE = '0; AWBURST = '0; WDATA = '0; WSTRB = '0;
    repeat (3) @(negedge ACLK);
    #1;
    chk({AWREADY, WREADY, BVALID, mem_valid} == 4'b0, "reset_ctrl",
        {AWREADY, WREADY, BVALID, mem_valid}, 64'd0);
    chk({BID, BRESP} == 6'b0, "reset_b", {BID, BRESP}, 64'd0);
    @(negedge ACLK);
    ARESET = 1'b0;
    #1;
    chk(!AWREADY, "awready_in_release", 64'(AWREADY), 64'd0);
    @(negedge ACLK); #1;
    chk(AWREADY, "awready_after_reset", 64'(AWREADY), 64'd1);

    for (int v = 0; v < 12; v++)
      run_burst(vec[v].id, vec[v].burst, vec[v].addr, vec[v].len,
                vec[v].sz, vec[v].bad, vec[v].rmode, vec[v].bhold,
                vec[v].resp);

    for (int r = 0; r < 40; r++) begin
      int b, len, sz, bad, bh;
      logic [31:0] a;
      logic [1:0] rs;
      b = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      sz = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
      if (b == 2 && $urandom_range(0, 4) != 0)
        len = (2 << $urandom_range(0, 3)) - 1;
      else
        len = int'($urandom_range(0, 15));
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & ~32'h7;
      if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFF0;
      bad = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len)) : -1;
      bh = int'($urandom_range(0, 3));
      rs = (model_err(b, a, len, sz) || bad >= 0) ? 2'b10 : 2'b00;
      run_burst(int'($urandom_range(0, 15)), b, a, len, sz, bad, 2, bh, rs);
    end

    // Reset in the middle of a burst must abandon it silently
    AWID = 4'h7; AWADDR = 32'h400; AWLEN = 8'd7; AWSIZE = 3'd2;
    AWBURST = 2'b01; AWVALID = 1'b1;
    #1;
    chk(AWREADY, "rst_aw_ready", 64'(AWREADY), 64'd1);
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b1; mem_ready = 1'b1;
    WDATA = 32'hA5A5_0000; WSTRB = 4'hF; WLAST = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b1;
    @(negedge ACLK); #1;
    chk({AWREADY, WREADY, BVALID, mem_valid} == 4'b0, "midrst_ctrl",
        {AWREADY, WREADY, BVALID, mem_valid}, 64'd0);
    chk({BID, BRESP} == 6'b0, "midrst_b", {BID, BRESP}, 64'd0);
    @(negedge ACLK);
    ARESET = 1'b0;
    #1;
    chk(!AWREADY, "midrst_release", 64'(AWREADY), 64'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge ACLK); #1;
      chk(AWREADY && !BVALID && !mem_valid && !WREADY, "post_rst_idle",
          {AWREADY, BVALID, mem_valid, WREADY}, 64'b1000);
    end
    WVALID = 1'b0; mem_ready = 1'b0;

    run_burst(4, 1, 32'h500, 1, 2, -1, 0, 0, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
